fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding/hazard unit for the pipelined core: next generation of the two-source EX-stage forwarding mux-select logic. It keeps its own shift pipeline of in-flight destination tags (one entry per stage past EX), resolves the youngest producer for every read port of the instruction in ID, and raises a load-use/multi-cycle stall when that producer's result is not ready. Forward selects are registered into EX alongside the instruction. Sits between the ID decoder and the EX operand muxes.

## Interface
- `NUM_RD`, 2: read ports per instruction (rs1, rs2, ...).
- `REG_AW`, 5: register address width.
- `DEPTH`, 2: tracked stages past ID (entry 0 = EX, entry DEPTH-1 = last stage before regfile write-through).
- `LAT_W`, 2: width of result-latency field.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_valid` in 1: instruction present in ID.
- `id_flush` in 1: kill ID instruction (branch resolved in EX).
- `ext_hold` in 1: global pipeline freeze (cache miss).
- `id_rs` in NUM_RD*REG_AW: source registers, port p at [p*REG_AW +: REG_AW].
- `id_rd` in REG_AW: destination register.
- `id_reg_write` in 1: instruction writes rd.
- `id_lat` in LAT_W: stages after EX before result is forwardable (0 = ALU, 1 = load, up to DEPTH-1).
- `id_stall` out 1: combinational; hold IF/ID, bubble into EX.
- `ex_fwd_sel` out NUM_RD*SEL_W: registered per-port select for EX, SEL_W = clog2(DEPTH+1); 0 = regfile, k = stage latch k (1 = EX/MEM, 2 = MEM/WB, ...).

## Operation
- Entry: {valid, rd, lat}; valid only when reg_write=1 and rd!=0.
- Advance (ext_hold=0): entries shift e[i+1]<=e[i]; e[DEPTH-1] dropped. e[0] <= ID instruction if id_valid & ~id_flush & ~id_stall, else bubble.
- Port match: for port p, youngest (lowest i) valid entry with e[i].rd == rs_p. rs_p==0 never matches.
- Ready: e[i] ready if e[i].lat <= i. Match ready -> next sel = i+1. Match not ready -> port hazard. No match -> sel 0.
- Youngest match decides; an older ready entry never overrides a younger not-ready one.
- id_stall = id_valid & ~id_flush & (any port hazard). id_flush suppresses stall.
- ex_fwd_sel on advance: selects of issued instruction; 0 on bubble (stall/flush/invalid).
- ext_hold=1: entries and ex_fwd_sel hold; id_stall still computed but has no state effect. ext_hold dominates stall and flush.
- id_lat >= DEPTH is illegal; treated as DEPTH-1.

## Timing
- Reset: all entries invalid, ex_fwd_sel = 0, id_stall = 0; counters 0.
- id_stall: zero-latency from ID inputs and current entries.
- ex_fwd_sel: valid one cycle after ID issue, in the same cycle the instruction is in EX.
- Load-use (lat=1, dependent next): exactly one stall cycle, then sel=2.
- lat=L, dependent next: L stall cycles, then sel=L+1.
- Reset mid-stall: deasserted next cycle with empty pipe; no stale selects.

## Configuration
- `FWD_PERF_CNT_EN` defined: adds outputs `stall_cnt` (32) and `fwd_cnt` (32); stall_cnt +1 per cycle id_stall=1 & ext_hold=0; fwd_cnt +1 per issued instruction with any nonzero sel; saturate at all-ones; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `fwd_pkg`: entry typedef (valid, rd, lat), `FWD_SEL_REGFILE = 0`, SEL_W function.
- Sub-module `fwd_port_match`: one per read port (generate loop); priority search over entries, returns {hit, ready, sel}. Top holds shift pipe, stall, output registers, counters.

## Test plan
- ALU chain: add x5; next add reads x5 as rs1 -> no stall, ex_fwd_sel port0 = 1; instruction after reads x5 -> sel 2.
- Load-use: lw x6 (lat=1); next reads x6 on rs2 -> id_stall 1 for one cycle, EX gets bubble (sel 0), then port1 sel = 2.
- x0 and youngest-wins: write x0 then read x0 -> sel 0, no stall; lw x7 then add x7 then read x7 -> sel 1 from add, no stall.
- Flush vs stall: load-use hazard with id_flush=1 -> id_stall 0, bubble into EX, sel 0.
- ext_hold: assert 3 cycles during pending load-use -> entries and ex_fwd_sel unchanged; release -> one stall cycle then sel 2.
- Reset mid-operation: reset pulse with 2 valid entries -> ex_fwd_sel 0, id_stall 0 next cycle for any rs; perf counters 0 (FWD_PERF_CNT_EN).

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_scoreboard shared types: in-flight entry, select encoding, select width.
// Optional perf counters in the top are enabled with `define FWD_PERF_CNT_EN.
package fwd_pkg;

  localparam int FWD_AW_MAX  = 8;
  localparam int FWD_LAT_MAX = 4;

  localparam int FWD_SEL_REGFILE = 0;

  typedef struct packed {
    logic                   valid;
    logic [FWD_AW_MAX-1:0]  rd;
    logic [FWD_LAT_MAX-1:0] lat;
  } entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-side bundle of the forwarding scoreboard.
// master = decoder / EX mux side, slave = fwd_scoreboard.
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int LAT_W  = 2
) ();

  localparam int SEL_W = sel_w(DEPTH);

  logic                     id_valid;
  logic                     id_flush;
  logic                     ext_hold;
  logic [NUM_RD*REG_AW-1:0] id_rs;
  logic [REG_AW-1:0]        id_rd;
  logic                     id_reg_write;
  logic [LAT_W-1:0]         id_lat;
  logic                     id_stall;
  logic [NUM_RD*SEL_W-1:0]  ex_fwd_sel;

  modport master (
    output id_valid, id_flush, ext_hold,
    output id_rs, id_rd, id_reg_write, id_lat,
    input  id_stall, ex_fwd_sel
  );

  modport slave (
    input  id_valid, id_flush, ext_hold,
    input  id_rs, id_rd, id_reg_write, id_lat,
    output id_stall, ex_fwd_sel
  );

endinterface

// File: rtl/fwd_port_match.sv
// Youngest-producer search for one read port over the in-flight entries.
// Returns hit, whether that producer is forwardable, and its stage select.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = 2
) (
  input  entry_t [DEPTH-1:0]    entries,
  input  logic [FWD_AW_MAX-1:0] rs,
  output logic                  hit,
  output logic                  ready,
  output logic [SEL_W-1:0]      sel
);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = SEL_W'(FWD_SEL_REGFILE);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && rs != '0 &&
          entries[i].rd == rs) begin
        hit   = 1'b1;
        ready = int'(entries[i].lat) <= i;
        sel   = SEL_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shift pipe of destination tags, stall, EX selects.
// `define FWD_PERF_CNT_EN adds saturating stall_cnt / fwd_cnt outputs.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int LAT_W  = 2
) (
  input  logic clk,
  input  logic reset,
  fwd_scoreboard_if.slave bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] fwd_cnt
`endif
);

  localparam int SEL_W = sel_w(DEPTH);
  localparam int SW    = NUM_RD * SEL_W;

  entry_t [DEPTH-1:0] pipe;
  entry_t             new_e;
  logic [LAT_W-1:0]   lat_c;
  logic [NUM_RD-1:0]  hit;
  logic [NUM_RD-1:0]  rdy;
  logic [SEL_W-1:0]   psel [NUM_RD];
  logic [SW-1:0]      nsel;
  logic               hazard;
  logic               stall;
  logic               issue;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .entries (pipe),
      .rs      (FWD_AW_MAX'(bus.id_rs[p*REG_AW +: REG_AW])),
      .hit     (hit[p]),
      .ready   (rdy[p]),
      .sel     (psel[p])
    );
  end

  // Hazard on any port; flush kills the ID instruction so it cannot stall.
  always_comb begin
    hazard = |(hit & ~rdy);
    stall  = bus.id_valid & ~bus.id_flush & hazard;
    issue  = bus.id_valid & ~bus.id_flush & ~stall;
  end

  assign bus.id_stall = stall;

  // Selects the issuing instruction will carry into EX; zero on bubble.
  always_comb begin
    nsel = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (issue && hit[p] && rdy[p]) begin
        nsel[p*SEL_W +: SEL_W] = psel[p];
      end
    end
  end

  // New EX entry; illegal latencies clamp to the last tracked stage.
  always_comb begin
    lat_c = bus.id_lat;
    if (int'(bus.id_lat) >= DEPTH) begin
      lat_c = LAT_W'(DEPTH - 1);
    end
    new_e = '0;
    if (issue && bus.id_reg_write && bus.id_rd != '0) begin
      new_e.valid = 1'b1;
      new_e.rd    = FWD_AW_MAX'(bus.id_rd);
      new_e.lat   = FWD_LAT_MAX'(lat_c);
    end
  end

  // Tag pipe and EX selects advance together unless frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe           <= '0;
      bus.ex_fwd_sel <= '0;
    end else if (!bus.ext_hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[0]        <= new_e;
      bus.ex_fwd_sel <= nsel;
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Saturating stall-cycle and forwarded-issue counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!bus.ext_hold) begin
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (issue && nsel != '0 && fwd_cnt != '1) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
